// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_pkg
// Purpose  : Shared defaults, sweep FSM encoding and byte-lane merge helper.
// Revision : 1.0
// ============================================================================
package reg_file_pkg;

    localparam int RF_DATA_WIDTH = 32;
    localparam int RF_ADDR_WIDTH = 5;
    // Widest word the merge helper handles; callers zero-extend and truncate.
    localparam int RF_MAX_DW     = 256;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } rf_state_t;

    function automatic logic [RF_MAX_DW-1:0] byte_merge(
        input logic [RF_MAX_DW-1:0]   old_w,
        input logic [RF_MAX_DW-1:0]   new_w,
        input logic [RF_MAX_DW/8-1:0] mask_L
    );
        logic [RF_MAX_DW-1:0] w_res;
        w_res = old_w;
        for (int i = 0; i < RF_MAX_DW/8; i++) begin
            if (!mask_L[i]) begin
                w_res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp_if
// Purpose  : Read/write port bundle between the decode stage and the register file.
// Revision : 1.0
// ============================================================================
interface reg_file_mp_if
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int NUM_RD     = 2
);
    logic [NUM_RD*ADDR_WIDTH-1:0] src_addr;
    logic [NUM_RD*DATA_WIDTH-1:0] src_datas_out;
    logic [ADDR_WIDTH-1:0]        dest_addr;
    logic [DATA_WIDTH-1:0]        write_datas_in;
    logic                         writeReg_L;
    logic [DATA_WIDTH/8-1:0]      byteWrite_L;
    logic                         clear_req;
    logic                         init_busy;

    modport master (
        output src_addr, dest_addr, write_datas_in, writeReg_L, byteWrite_L, clear_req,
        input  src_datas_out, init_busy
    );

    modport slave (
        input  src_addr, dest_addr, write_datas_in, writeReg_L, byteWrite_L, clear_req,
        output src_datas_out, init_busy
    );
endinterface
`default_nettype wire

// File: rtl/reg_clear_seq.sv
`default_nettype none
// ============================================================================
// Module   : reg_clear_seq
// Purpose  : Clear-sweep FSM: walks every entry writing zero after reset or on request.
// Revision : 1.0
// ============================================================================
module reg_clear_seq
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DEPTH      = 32
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  i_clear_req,
    output logic [ADDR_WIDTH-1:0]      o_clr_addr,
    output logic                       o_clr_we,
    output logic                       o_clearing,
    output logic                       o_init_busy
);
    localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(DEPTH - 1);

    rf_state_t             r_state;
    rf_state_t             w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_clr_we    = 1'b0;
        o_clearing  = 1'b0;
        o_init_busy = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                o_clr_we    = 1'b1;
                o_clearing  = 1'b1;
                o_init_busy = 1'b1;
                if (r_cnt == c_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt   = r_cnt + ADDR_WIDTH'(1);
                end
            end
            ST_IDLE: begin
                if (i_clear_req) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_clr_addr = r_cnt;

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_mp
// Purpose  : DEPTH x DATA_WIDTH register file, NUM_RD read ports, byte-masked write, clear sweep.
// Revision : 1.0
// ============================================================================
module reg_file_mp
    import reg_file_pkg::*;
#(
    parameter int DATA_WIDTH = RF_DATA_WIDTH,
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DEPTH      = 32,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  wire logic     CLOCK,
    input  wire logic     RESET,
    reg_file_mp_if.slave  bus
);
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_clr_we;
    logic                  w_clearing;
    logic                  w_wr_valid;
    logic [DATA_WIDTH-1:0] w_old;
    logic [DATA_WIDTH-1:0] w_merged;

    reg_clear_seq #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_clear_seq (
        .clk         (CLOCK),
        .rst         (RESET),
        .i_clear_req (bus.clear_req),
        .o_clr_addr  (w_clr_addr),
        .o_clr_we    (w_clr_we),
        .o_clearing  (w_clearing),
        .o_init_busy (bus.init_busy)
    );

    // A write on the edge that launches a sweep is discarded along with it.
    assign w_wr_valid = !bus.writeReg_L && !w_clearing && !bus.clear_req
                        && (32'(bus.dest_addr) < DEPTH)
                        && !((ZERO_REG != 0) && (bus.dest_addr == '0));

    assign w_old    = r_mem[bus.dest_addr[c_IDX_W-1:0]];
    assign w_merged = DATA_WIDTH'(byte_merge(RF_MAX_DW'(w_old),
                                             RF_MAX_DW'(bus.write_datas_in),
                                             (RF_MAX_DW/8)'(bus.byteWrite_L)));

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        always_ff @(posedge CLOCK) begin
            if (w_clr_we && (w_clr_addr == ADDR_WIDTH'(e))) begin
                r_mem[e] <= '0;
            end else if (w_wr_valid && (bus.dest_addr == ADDR_WIDTH'(e))) begin
                r_mem[e] <= w_merged;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic                  w_ok;
        logic                  w_hit;
        logic [DATA_WIDTH-1:0] w_stored;

        assign w_ra     = bus.src_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_ok     = (32'(w_ra) < DEPTH) && !((ZERO_REG != 0) && (w_ra == '0));
        assign w_stored = w_ok ? r_mem[w_ra[c_IDX_W-1:0]] : '0;
        assign w_hit    = (BYPASS != 0) && w_wr_valid && (w_ra == bus.dest_addr);
        assign bus.src_datas_out[k*DATA_WIDTH +: DATA_WIDTH] =
            w_clearing ? '0 : (w_hit ? w_merged : w_stored);
    end

endmodule
`default_nettype wire
